// File: rtl/alu_pkg.sv
//==============================================================================
// Package : alu_pkg
// Brief   : Opcode, one-hot ALU OP, FSM state and CCR bit definitions shared by
//           the ALU issue sequencer and its opcode decoder.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package alu_pkg;

  localparam int c_OP_W         = 7;
  localparam int c_OPC_MASK_BIT = 4;

  localparam logic [4:0] c_OPC_NOP = 5'h00;
  localparam logic [4:0] c_OPC_ADD = 5'h01;
  localparam logic [4:0] c_OPC_SUB = 5'h02;
  localparam logic [4:0] c_OPC_AND = 5'h03;
  localparam logic [4:0] c_OPC_OR  = 5'h04;
  localparam logic [4:0] c_OPC_NOT = 5'h05;
  localparam logic [4:0] c_OPC_SHR = 5'h06;
  localparam logic [4:0] c_OPC_SHL = 5'h07;

  localparam logic [c_OP_W-1:0] c_OP_NONE = 7'b0000000;
  localparam logic [c_OP_W-1:0] c_OP_ADD  = 7'b0000001;
  localparam logic [c_OP_W-1:0] c_OP_SUB  = 7'b0000010;
  localparam logic [c_OP_W-1:0] c_OP_AND  = 7'b0000100;
  localparam logic [c_OP_W-1:0] c_OP_OR   = 7'b0001000;
  localparam logic [c_OP_W-1:0] c_OP_NOT  = 7'b0010000;
  localparam logic [c_OP_W-1:0] c_OP_SHR  = 7'b0100000;
  localparam logic [c_OP_W-1:0] c_OP_SHL  = 7'b1000000;

  typedef logic [1:0] state_t;
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_WB   = 2'd2;

  // Ccr layout is {N,C,Z}
  localparam int c_CCR_Z = 0;
  localparam int c_CCR_C = 1;
  localparam int c_CCR_N = 2;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
//==============================================================================
// Module : alu_op_decode
// Brief  : Combinational binary opcode -> one-hot ALU OP, legal/NOP/flag-update.
// Config : ALU_SEQ_FLAG_MASK_EN enables flag-suppressed aliases 0x11..0x17.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0]        opcode,
  output logic [c_OP_W-1:0] aluOp,
  output logic              legal,
  output logic              isNop,
  output logic              flagUpd
);

  logic       w_inRange;
  logic [4:0] w_base;

`ifdef ALU_SEQ_FLAG_MASK_EN
  // 0x11..0x17 alias 0x01..0x07 with flags held; 0x10 has no NOP alias
  assign w_inRange = !opcode[3] && !(opcode[c_OPC_MASK_BIT] && (opcode[2:0] == 3'd0));
`else
  assign w_inRange = (opcode[4:3] == 2'b00);
`endif

  assign w_base = {1'b0, opcode[3:0]};

  always_comb begin
    aluOp   = c_OP_NONE;
    legal   = w_inRange;
    isNop   = 1'b0;
    flagUpd = !opcode[c_OPC_MASK_BIT];
    if (w_inRange) begin
      case (w_base)
        c_OPC_NOP: isNop = 1'b1;
        c_OPC_ADD: aluOp = c_OP_ADD;
        c_OPC_SUB: aluOp = c_OP_SUB;
        c_OPC_AND: aluOp = c_OP_AND;
        c_OPC_OR:  aluOp = c_OP_OR;
        c_OPC_NOT: aluOp = c_OP_NOT;
        c_OPC_SHR: aluOp = c_OP_SHR;
        c_OPC_SHL: aluOp = c_OP_SHL;
        default:   legal = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
//==============================================================================
// Module : alu_op_sequencer
// Brief  : ALU issue sequencer: IDLE -> EXEC -> WB, one instruction in flight,
//          captures Result and {N,C,Z} into Ccr, valid/ready on both sides.
// Config : ALU_SEQ_FLAG_MASK_EN (see alu_op_decode) suppresses Ccr update.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int OP_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [4:0]            InOpcode,
  input  logic [REG_ADDR_W-1:0] InDst,
  input  logic [WIDTH-1:0]      InFirst,
  input  logic [WIDTH-1:0]      InSecond,
  output logic [WIDTH-1:0]      AluFirst,
  output logic [WIDTH-1:0]      AluSecond,
  output logic [OP_W-1:0]       AluOp,
  output logic                  AluEn,
  input  logic [WIDTH-1:0]      AluResult,
  input  logic                  AluZero,
  input  logic                  AluCarry,
  input  logic                  AluNeg,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [WIDTH-1:0]      OutResult,
  output logic [REG_ADDR_W-1:0] OutDst,
  output logic                  OutWrite,
  output logic [2:0]            Ccr,
  output logic                  IllegalOp
);

  state_t                r_state;
  logic [WIDTH-1:0]      r_aluFirst;
  logic [WIDTH-1:0]      r_aluSecond;
  logic [OP_W-1:0]       r_aluOp;
  logic                  r_aluEn;
  logic [WIDTH-1:0]      r_outResult;
  logic [REG_ADDR_W-1:0] r_outDst;
  logic                  r_outWrite;
  logic [2:0]            r_ccr;
  logic                  r_flagUpd;
  logic                  r_illegalOp;

  logic [OP_W-1:0]       w_decOp;
  logic                  w_legal;
  logic                  w_isNop;
  logic                  w_flagUpd;

  alu_op_decode u_decode (
    .opcode  (InOpcode),
    .aluOp   (w_decOp),
    .legal   (w_legal),
    .isNop   (w_isNop),
    .flagUpd (w_flagUpd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_aluFirst  <= '0;
      r_aluSecond <= '0;
      r_aluOp     <= '0;
      r_aluEn     <= 1'b0;
      r_outResult <= '0;
      r_outDst    <= '0;
      r_outWrite  <= 1'b0;
      r_ccr       <= 3'b000;
      r_flagUpd   <= 1'b0;
      r_illegalOp <= 1'b0;
    end else begin
      r_illegalOp <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (InValid) begin
            if (w_isNop) begin
              r_outDst   <= InDst;
              r_outWrite <= 1'b0;
              r_state    <= c_ST_WB;
            end else if (w_legal) begin
              r_aluFirst  <= InFirst;
              r_aluSecond <= InSecond;
              r_aluOp     <= w_decOp;
              r_aluEn     <= 1'b1;
              r_outDst    <= InDst;
              r_flagUpd   <= w_flagUpd;
              r_state     <= c_ST_EXEC;
            end else begin
              // Illegal opcodes are consumed and reported, nothing else moves
              r_illegalOp <= 1'b1;
            end
          end
        end
        c_ST_EXEC: begin
          r_aluEn     <= 1'b0;
          r_aluOp     <= '0;
          r_outResult <= AluResult;
          r_outWrite  <= 1'b1;
          if (r_flagUpd) begin
            r_ccr[c_CCR_N] <= AluNeg;
            r_ccr[c_CCR_C] <= AluCarry;
            r_ccr[c_CCR_Z] <= AluZero;
          end
          r_state <= c_ST_WB;
        end
        c_ST_WB: begin
          if (OutReady) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign InReady   = (r_state == c_ST_IDLE);
  assign OutValid  = (r_state == c_ST_WB);
  assign AluFirst  = r_aluFirst;
  assign AluSecond = r_aluSecond;
  assign AluOp     = r_aluOp;
  assign AluEn     = r_aluEn;
  assign OutResult = r_outResult;
  assign OutDst    = r_outDst;
  assign OutWrite  = r_outWrite;
  assign Ccr       = r_ccr;
  assign IllegalOp = r_illegalOp;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
//==============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Self-checking bench for alu_op_sequencer with a behavioural ALU and
//          an expected-result queue. Honors ALU_SEQ_FLAG_MASK_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InOpcode;
  logic [2:0]  InDst;
  logic [15:0] InFirst;
  logic [15:0] InSecond;
  logic [15:0] AluFirst;
  logic [15:0] AluSecond;
  logic [6:0]  AluOp;
  logic        AluEn;
  logic [15:0] AluResult;
  logic        AluZero;
  logic        AluCarry;
  logic        AluNeg;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] OutResult;
  logic [2:0]  OutDst;
  logic        OutWrite;
  logic [2:0]  Ccr;
  logic        IllegalOp;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  dst;
    logic        wr;
    logic [2:0]  ccr;
  } exp_t;

  exp_t       sbQ[$];
  logic [2:0] modelCcr;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .InValid   (InValid),
    .InReady   (InReady),
    .InOpcode  (InOpcode),
    .InDst     (InDst),
    .InFirst   (InFirst),
    .InSecond  (InSecond),
    .AluFirst  (AluFirst),
    .AluSecond (AluSecond),
    .AluOp     (AluOp),
    .AluEn     (AluEn),
    .AluResult (AluResult),
    .AluZero   (AluZero),
    .AluCarry  (AluCarry),
    .AluNeg    (AluNeg),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutResult (OutResult),
    .OutDst    (OutDst),
    .OutWrite  (OutWrite),
    .Ccr       (Ccr),
    .IllegalOp (IllegalOp)
  );

  // Behavioural ALU: returns {N,C,Z,Result}
  function automatic logic [18:0] aluCalc(input logic [6:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic        c;
    t = '0; r = '0; c = 1'b0;
    case (op)
      7'b0000001: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16]; end
      7'b0000010: begin t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16]; end
      7'b0000100: r = a & b;
      7'b0001000: r = a | b;
      7'b0010000: r = ~a;
      7'b0100000: begin t = {a, 1'b0} >> b[3:0]; r = t[16:1]; c = t[0]; end
      7'b1000000: begin t = {1'b0, a} << b[3:0]; r = t[15:0]; c = t[16]; end
      default:    r = '0;
    endcase
    return {r[15], c, (r == 16'h0000), r};
  endfunction

  function automatic logic [6:0] opcToOneHot(input logic [2:0] base);
    case (base)
      3'd1:    return 7'b0000001;
      3'd2:    return 7'b0000010;
      3'd3:    return 7'b0000100;
      3'd4:    return 7'b0001000;
      3'd5:    return 7'b0010000;
      3'd6:    return 7'b0100000;
      3'd7:    return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Garbage outside En so a capture at the wrong edge shows up
  logic [18:0] aluOut;
  always_comb begin
    aluOut = 19'h7_DEAD;
    if (AluEn) aluOut = aluCalc(AluOp, AluFirst, AluSecond);
  end
  assign {AluNeg, AluCarry, AluZero, AluResult} = aluOut;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [4:0] opc, input logic [2:0] dst, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [18:0] r;
    e.dst = dst;
    if (opc[2:0] == 3'd0) begin
      e.res = '0;
      e.wr  = 1'b0;
    end else begin
      r     = aluCalc(opcToOneHot(opc[2:0]), a, b);
      e.res = r[15:0];
      e.wr  = 1'b1;
      if (!opc[4]) modelCcr = r[18:16];
    end
    e.ccr = modelCcr;
    sbQ.push_back(e);
  endtask

  task automatic issue(input logic [4:0] opc, input logic [2:0] dst, input logic [15:0] a, input logic [15:0] b);
    InValid  = 1'b1;
    InOpcode = opc;
    InDst    = dst;
    InFirst  = a;
    InSecond = b;
    tick();
    InValid  = 1'b0;
    InFirst  = 16'($urandom);
    InSecond = 16'($urandom);
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (OutValid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic ack();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({AluEn, AluOp, AluFirst, AluSecond, OutValid, OutResult, OutDst, OutWrite, Ccr, IllegalOp} !== 65'd0) begin
      bad++;
      $display("FAIL reset_outputs: got En=%b Op=%b F=%h S=%h V=%b R=%h D=%0d W=%b Ccr=%b Ill=%b, want all zero",
               AluEn, AluOp, AluFirst, AluSecond, OutValid, OutResult, OutDst, OutWrite, Ccr, IllegalOp);
    end
    rst = 1'b0;
    tick();
    total++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: InReady=%b OutValid=%b, want 1/0", InReady, OutValid);
    end

    // Reset while ADD 5+3 sits in EXEC
    issue(5'h01, 3'd1, 16'd5, 16'd3);
    total++;
    if (AluEn !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_exec: AluEn=%b, want 1", AluEn);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({InReady, AluEn, AluOp, AluFirst, AluSecond, OutValid, OutResult, OutDst, OutWrite, Ccr, IllegalOp} !== {1'b1, 65'd0}) begin
      bad++;
      $display("FAIL reset_mid_exec: got Rdy=%b En=%b Op=%b F=%h S=%h V=%b R=%h D=%0d W=%b Ccr=%b Ill=%b, want Rdy=1 rest zero",
               InReady, AluEn, AluOp, AluFirst, AluSecond, OutValid, OutResult, OutDst, OutWrite, Ccr, IllegalOp);
    end
    modelCcr = 3'b000;
    tick();
    rst = 1'b0;
    begin
      bit sawValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (OutValid) sawValid = 1'b1;
      end
      total++;
      if (sawValid || Ccr !== 3'b000) begin
        bad++;
        $display("FAIL reset_drop: OutValid seen=%b Ccr=%b, want 0/000", sawValid, Ccr);
      end
    end
  endtask

  task automatic test_add_carry();
    bit   ok;
    exp_t e;
    pushExp(5'h01, 3'd2, 16'hFFFF, 16'h0001);
    issue(5'h01, 3'd2, 16'hFFFF, 16'h0001);
    total++;
    if (AluEn !== 1'b1 || AluOp !== 7'b0000001 || AluFirst !== 16'hFFFF || AluSecond !== 16'h0001 || OutValid !== 1'b0) begin
      bad++;
      $display("FAIL add_exec: En=%b Op=%b F=%h S=%h V=%b, want 1/0000001/FFFF/0001/0", AluEn, AluOp, AluFirst, AluSecond, OutValid);
    end
    tick();
    total++;
    if (AluEn !== 1'b0 || AluOp !== 7'b0 || OutValid !== 1'b1 || Ccr !== 3'b011) begin
      bad++;
      $display("FAIL add_wb: En=%b Op=%b V=%b Ccr=%b, want 0/0000000/1/011", AluEn, AluOp, OutValid, Ccr);
    end
    waitValid(ok);
    e = sbQ.pop_front();
    total++;
    if (!ok || {OutResult, OutDst, OutWrite, Ccr} !== e) begin
      bad++;
      $display("FAIL add_result: got R=%h D=%0d W=%b Ccr=%b, want R=%h D=%0d W=%b Ccr=%b",
               OutResult, OutDst, OutWrite, Ccr, e.res, e.dst, e.wr, e.ccr);
    end
    ack();
    total++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      bad++;
      $display("FAIL add_return_idle: InReady=%b OutValid=%b, want 1/0", InReady, OutValid);
    end
  endtask

  task automatic test_sub_latency();
    exp_t e;
    pushExp(5'h02, 3'd4, 16'd3, 16'd5);
    issue(5'h02, 3'd4, 16'd3, 16'd5);
    total++;
    if (OutValid !== 1'b0) begin
      bad++;
      $display("FAIL sub_early_valid: OutValid=%b one edge after accept, want 0", OutValid);
    end
    tick();
    e = sbQ.pop_front();
    total++;
    if (OutValid !== 1'b1 || {OutResult, OutDst, OutWrite, Ccr} !== e || e.res !== 16'hFFFE || e.ccr !== 3'b110) begin
      bad++;
      $display("FAIL sub_result: V=%b R=%h D=%0d W=%b Ccr=%b, want V=1 R=FFFE D=4 W=1 Ccr=110",
               OutValid, OutResult, OutDst, OutWrite, Ccr);
    end
    ack();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   stallBad = 1'b0;
    pushExp(5'h04, 3'd6, 16'h8000, 16'h0001);
    issue(5'h04, 3'd6, 16'h8000, 16'h0001);
    tick();
    e = sbQ[0];
    // Illegal op offered while stalled must not be taken
    InValid  = 1'b1;
    InOpcode = 5'h09;
    for (int i = 0; i < 10; i++) begin
      if (OutValid !== 1'b1 || InReady !== 1'b0 || IllegalOp !== 1'b0 ||
          {OutResult, OutDst, OutWrite, Ccr} !== e) stallBad = 1'b1;
      tick();
    end
    InValid = 1'b0;
    total++;
    if (stallBad) begin
      bad++;
      $display("FAIL backpressure_hold: V=%b Rdy=%b Ill=%b R=%h D=%0d W=%b Ccr=%b, want V=1 Rdy=0 Ill=0 R=%h D=%0d W=%b Ccr=%b",
               OutValid, InReady, IllegalOp, OutResult, OutDst, OutWrite, Ccr, e.res, e.dst, e.wr, e.ccr);
    end
    void'(sbQ.pop_front());
    ack();
    total++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release: InReady=%b OutValid=%b, want 1/0", InReady, OutValid);
    end
  endtask

  task automatic test_illegal_nop();
    bit   ok;
    exp_t e;
    issue(5'h09, 3'd7, 16'h1234, 16'h5678);
    total++;
    if (IllegalOp !== 1'b1 || InReady !== 1'b1 || Ccr !== modelCcr || OutValid !== 1'b0 || AluEn !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: Ill=%b Rdy=%b Ccr=%b V=%b En=%b, want 1/1/%b/0/0", IllegalOp, InReady, Ccr, OutValid, AluEn, modelCcr);
    end
    tick();
    total++;
    if (IllegalOp !== 1'b0 || InReady !== 1'b1) begin
      bad++;
      $display("FAIL illegal_single: Ill=%b Rdy=%b, want 0/1", IllegalOp, InReady);
    end

    pushExp(5'h00, 3'd5, 16'h0, 16'h0);
    issue(5'h00, 3'd5, 16'hAAAA, 16'h5555);
    waitValid(ok);
    e = sbQ.pop_front();
    total++;
    if (!ok || OutDst !== e.dst || OutWrite !== 1'b0 || Ccr !== e.ccr) begin
      bad++;
      $display("FAIL nop_wb: ok=%b D=%0d W=%b Ccr=%b, want D=%0d W=0 Ccr=%b", ok, OutDst, OutWrite, Ccr, e.dst, e.ccr);
    end
    ack();
  endtask

  task automatic test_flag_mask();
`ifdef ALU_SEQ_FLAG_MASK_EN
    bit   ok;
    exp_t e;
    pushExp(5'h12, 3'd3, 16'd7, 16'd7);
    issue(5'h12, 3'd3, 16'd7, 16'd7);
    total++;
    if (AluOp !== 7'b0000010 || AluEn !== 1'b1) begin
      bad++;
      $display("FAIL mask_exec: Op=%b En=%b, want 0000010/1", AluOp, AluEn);
    end
    waitValid(ok);
    e = sbQ.pop_front();
    total++;
    if (!ok || {OutResult, OutDst, OutWrite, Ccr} !== e) begin
      bad++;
      $display("FAIL mask_result: R=%h D=%0d W=%b Ccr=%b, want R=%h D=%0d W=%b Ccr=%b",
               OutResult, OutDst, OutWrite, Ccr, e.res, e.dst, e.wr, e.ccr);
    end
    ack();
`else
    issue(5'h12, 3'd3, 16'd7, 16'd7);
    total++;
    if (IllegalOp !== 1'b1 || InReady !== 1'b1 || AluEn !== 1'b0) begin
      bad++;
      $display("FAIL op12_illegal: Ill=%b Rdy=%b En=%b, want 1/1/0", IllegalOp, InReady, AluEn);
    end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    bit          ok;
    exp_t        e;
    logic [4:0]  opc;
    logic [2:0]  dst;
    logic [15:0] a;
    logic [15:0] b;
    OutReady = 1'b1;
    for (int i = 0; i < 14; i++) begin
      opc = 5'((i % 7) + 1);
      dst = 3'($urandom);
      a   = (i < 7) ? 16'($urandom) : 16'hFFFF;
      b   = (i < 7) ? 16'($urandom) : 16'h0001;
      pushExp(opc, dst, a, b);
      issue(opc, dst, a, b);
      waitValid(ok);
      e = sbQ.pop_front();
      total++;
      if (!ok || {OutResult, OutDst, OutWrite, Ccr} !== e) begin
        bad++;
        $display("FAIL b2b_op%0d_%0d: ok=%b R=%h D=%0d W=%b Ccr=%b, want R=%h D=%0d W=%b Ccr=%b",
                 opc, i, ok, OutResult, OutDst, OutWrite, Ccr, e.res, e.dst, e.wr, e.ccr);
      end
      tick();
    end
    OutReady = 1'b0;
    total++;
    if (sbQ.size() != 0 || InReady !== 1'b1) begin
      bad++;
      $display("FAIL b2b_drain: queue=%0d InReady=%b, want 0/1", sbQ.size(), InReady);
    end
  endtask

  initial begin
    rst      = 1'b1;
    InValid  = 1'b0;
    InOpcode = '0;
    InDst    = '0;
    InFirst  = '0;
    InSecond = '0;
    OutReady = 1'b0;
    modelCcr = 3'b000;
    test_reset();
    test_add_carry();
    test_sub_latency();
    test_backpressure();
    test_illegal_nop();
    test_flag_mask();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
